ch_pack: RTL

CH_PACK -- requirements
Module: ch_pack

---
 rtl/ch_pack.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ch_pack.sv
// Channel sample packer: buffers {sof, I, Q} samples and streams them
// to the RX FIFO as I/Q word pairs, with frame resync after any overrun.
module ch_pack #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        strobe,
   input  logic [2:0]  sel,
   input  logic [2:0]  channels,
   input  logic [15:0] data_i,
   input  logic [15:0] data_q,
   input  logic        fifo_full,
   output logic        wr_en,
   output logic [15:0] wr_data,
   output logic        sof,
   output logic        overrun,
   output logic [15:0] overrun_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW + 1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      EMIT_I,
      EMIT_Q
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [32:0]   mem [DEPTH];
   logic [32:0]   head;
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic          sync;
   logic          qual;
   logic          push;
   logic          pop;
   logic          drop;
   logic          wr_en_nxt;
   logic [15:0]   wr_data_nxt;
   logic          sof_nxt;

   // While resyncing only a channel-0 sample may start the stream.
   assign qual = strobe && enable && (sel <= channels)
              && (!sync || sel == 3'd0);
   assign pop  = (state == EMIT_Q) && !fifo_full;
   assign drop = qual && (count == FULL) && !pop;
   assign push = qual && !drop;
   assign head = mem[rptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= {sel == 3'd0, data_i, data_q};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         sync        <= 1'b1;
         overrun     <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
         if (drop) begin
            sync    <= 1'b1;
            overrun <= 1'b1;
            if (overrun_cnt != 16'hFFFF) begin
               overrun_cnt <= overrun_cnt + 16'd1;
            end
         end else if (push) begin
            sync <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (count != '0) begin
               state_nxt = EMIT_I;
            end
         end
         EMIT_I: begin
            if (!fifo_full) begin
               state_nxt = EMIT_Q;
            end
         end
         EMIT_Q: begin
            if (!fifo_full) begin
               state_nxt = (count > ONE) ? EMIT_I : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wr_en_nxt   = 1'b0;
      wr_data_nxt = wr_data;
      sof_nxt     = sof;
      if (state == EMIT_I && !fifo_full) begin
         wr_en_nxt   = 1'b1;
         wr_data_nxt = head[31:16];
         sof_nxt     = head[32];
      end else if (state == EMIT_Q && !fifo_full) begin
         wr_en_nxt   = 1'b1;
         wr_data_nxt = head[15:0];
         sof_nxt     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_data <= '0;
         sof     <= 1'b0;
      end else begin
         wr_en   <= wr_en_nxt;
         wr_data <= wr_data_nxt;
         sof     <= sof_nxt;
      end
   end

endmodule
